// File: rtl/compress_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | compress_stream: per-lane float32 classifier/compressor, 2-stage pipe    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module compress_stream #(
  parameter int LANES  = 4,
  parameter int HI_EXP = 127,
  parameter int LO_EXP = 111,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*LANES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_data,
  output logic [2*LANES-1:0]  out_status,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    cnt_zero,
  output logic [CNT_W-1:0]    cnt_half,
  output logic [CNT_W-1:0]    cnt_full
);

  localparam logic [1:0] ST_ZERO = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b10;
  localparam logic [1:0] ST_FULL = 2'b11;
  localparam logic [7:0] HI_E    = 8'(HI_EXP);
  localparam logic [7:0] LO_E    = 8'(LO_EXP);
  localparam int         NW      = $clog2(LANES + 1);

  logic                s1_valid_q, s2_valid_q;
  logic [2*LANES-1:0]  s1_cls_q, s1_cls_d, s2_cls_q;
  logic [8*LANES-1:0]  s1_sh_q, s1_sh_d;
  logic [32*LANES-1:0] s1_data_q, s2_data_q, s2_data_d;
  logic                s1_adv, in_fire, out_fire;
  logic [NW-1:0]       n_zero, n_half, n_full;
  logic [CNT_W-1:0]    cnt_zero_q, cnt_half_q, cnt_full_q;
  logic [CNT_W-1:0]    cnt_zero_d, cnt_half_d, cnt_full_d;

  assign s1_adv     = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready   = ~s1_valid_q | s1_adv;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = s2_valid_q & out_ready;
  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_status = s2_cls_q;
  assign cnt_zero   = cnt_zero_q;
  assign cnt_half   = cnt_half_q;
  assign cnt_full   = cnt_full_q;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [7:0]  exp_w;
      logic [1:0]  cls_w;
      logic [23:0] mant_w;
      logic [14:0] q_w;

      assign exp_w = in_data[32*i+23 +: 8];
      assign s1_cls_d[2*i +: 2] = !enable        ? ST_FULL :
                                  (exp_w > HI_E)  ? ST_FULL :
                                  (exp_w <= LO_E) ? ST_ZERO : ST_HALF;
      assign s1_sh_d[8*i +: 8] = HI_E - exp_w;

      // Shifting by sh+9 yields bits [23:9] of (m >> sh) directly.
      assign cls_w  = s1_cls_q[2*i +: 2];
      assign mant_w = {1'b1, s1_data_q[32*i +: 23]};
      assign q_w    = 15'(mant_w >> ({1'b0, s1_sh_q[8*i +: 8]} + 9'd9));
      assign s2_data_d[32*i +: 32] = (cls_w == ST_ZERO) ? 32'h0 :
                                     (cls_w == ST_HALF) ? {s1_data_q[32*i+31], q_w, 16'h0} :
                                     s1_data_q[32*i +: 32];
    end
  endgenerate

  always_comb begin
    n_zero = '0;
    n_half = '0;
    n_full = '0;
    for (int i = 0; i < LANES; i++) begin
      case (out_status[2*i +: 2])
        ST_ZERO: n_zero = n_zero + NW'(1);
        ST_HALF: n_half = n_half + NW'(1);
        ST_FULL: n_full = n_full + NW'(1);
        default: ;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [NW-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Clear takes priority over a coincident output handshake.
  assign cnt_zero_d = cnt_clear ? '0 : out_fire ? sat_add(cnt_zero_q, n_zero) : cnt_zero_q;
  assign cnt_half_d = cnt_clear ? '0 : out_fire ? sat_add(cnt_half_q, n_half) : cnt_half_q;
  assign cnt_full_d = cnt_clear ? '0 : out_fire ? sat_add(cnt_full_q, n_full) : cnt_full_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= '0;
      s1_sh_q    <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_cls_q   <= '0;
      s2_data_q  <= '0;
      cnt_zero_q <= '0;
      cnt_half_q <= '0;
      cnt_full_q <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_cls_q  <= s1_cls_d;
        s1_sh_q   <= s1_sh_d;
        s1_data_q <= in_data;
      end
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        s2_cls_q   <= s1_cls_q;
        s2_data_q  <= s2_data_d;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
      cnt_zero_q <= cnt_zero_d;
      cnt_half_q <= cnt_half_d;
      cnt_full_q <= cnt_full_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compress_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_compress_stream: directed self-checking bench for compress_stream     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_compress_stream;

  logic         clk = 1'b0;
  logic         resetn, enable, in_valid, out_ready, cnt_clear;
  logic [127:0] in_data;
  logic         in_ready, out_valid;
  logic [127:0] out_data;
  logic [7:0]   out_status;
  logic [31:0]  cnt_zero, cnt_half, cnt_full;

  logic         in_ready2, out_valid2;
  logic [127:0] out_data2;
  logic [7:0]   out_status2;
  logic [3:0]   cnt_zero2, cnt_half2, cnt_full2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  compress_stream dut (
    .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_status(out_status), .cnt_clear(cnt_clear), .cnt_zero(cnt_zero), .cnt_half(cnt_half),
    .cnt_full(cnt_full)
  );

  compress_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_status(out_status2), .cnt_clear(cnt_clear), .cnt_zero(cnt_zero2), .cnt_half(cnt_half2),
    .cnt_full(cnt_full2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Stream beat k: lanes chosen so each result is a simple hand-derived function of k.
  function automatic logic [127:0] beat_in(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return pack4(32'h3F800000 | (kk << 9), 32'h40000000 + kk, kk, 32'hBF000000 | (kk << 10));
  endfunction

  function automatic logic [127:0] beat_out(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return pack4(32'h40000000 | (kk << 16), 32'h40000000 + kk, 32'h0, 32'hA0000000 | (kk << 16));
  endfunction

  logic [127:0] v1, v2, v3, r1, r2, half4;

  initial begin
    v1    = pack4(32'h3F800000, 32'h3F000000, 32'hBF000000, 32'h40000000);
    r1    = pack4(32'h40000000, 32'h20000000, 32'hA0000000, 32'h40000000);
    v2    = pack4(32'h37800000, 32'h00000000, 32'h7FC00000, 32'h38000000);
    r2    = pack4(32'h00000000, 32'h00000000, 32'h7FC00000, 32'h00000000);
    v3    = pack4(32'h3F000000, 32'h37800000, 32'h40400000, 32'h00000001);
    half4 = {4{32'h3F800000}};

    resetn = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clear = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_status", out_status, 0);
    check("rst_cnt_full", cnt_full, 0);
    @(negedge clk) resetn = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Back-to-back beats; the third is presented with enable low.
    in_valid = 1'b1; in_data = v1; enable = 1'b1;
    tick();
    check("lat_not_yet", out_valid, 0);
    in_data = v2;
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, r1);
    check("t1_status", out_status, 8'hEA);
    in_data = v3; enable = 1'b0;
    tick();
    in_valid = 1'b0; enable = 1'b1;
    check("t2_data", out_data, r2);
    check("t2_status", out_status, 8'hB0);
    check("t1_cnt_half", cnt_half, 3);
    check("t1_cnt_full", cnt_full, 1);
    tick();
    check("t3_data", out_data, v3);
    check("t3_status", out_status, 8'hFF);
    check("t2_cnt_zero", cnt_zero, 2);
    check("t2_cnt_half", cnt_half, 4);
    tick();
    check("t3_cnt_full", cnt_full, 6);
    check("t3_drained", out_valid, 0);

    // Stream under out_ready pattern 1,0,0 with random input gaps.
    begin
      int kin, kout, cyc;
      logic acc_in, acc_out;
      kin = 0; kout = 0; cyc = 0;
      while (kout < 16 && cyc < 300) begin
        out_ready = (cyc % 3 == 0);
        if (kin < 16) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = beat_in(kin);
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        acc_in  = in_valid & in_ready;
        acc_out = out_valid & out_ready;
        if (out_valid) begin
          check("s4_data", out_data, beat_out(kout));
          check("s4_status", out_status, 8'h8E);
        end
        tick();
        if (acc_in) kin++;
        if (acc_out) kout++;
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("s4_in_count", kin, 16);
      check("s4_out_count", kout, 16);
      tick();
      check("s4_no_dup", out_valid, 0);
    end

    // Saturation on the 4-bit counter instance.
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("s5_cleared", cnt_half2, 0);
    in_valid = 1'b1; in_data = half4;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("s5_sat", cnt_half2, 15);
    check("s5_wide", cnt_half, 20);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("s5_hs_valid", out_valid, 1);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("s5_clr_wins4", cnt_half2, 0);
    check("s5_clr_wins", cnt_half, 0);

    // Async reset with both stages full.
    in_valid = 1'b1; in_data = v1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("s6_pre_cnt", cnt_half, 3);
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_data = v3;
    tick();
    in_valid = 1'b0;
    check("s6_full_valid", out_valid, 1);
    check("s6_full_ready", in_ready, 0);
    #2 resetn = 1'b0;
    #1;
    check("s6_rst_valid", out_valid, 0);
    check("s6_rst_data", out_data, 0);
    check("s6_rst_status", out_status, 0);
    check("s6_rst_half", cnt_half, 0);
    check("s6_rst_full", cnt_full, 0);
    @(negedge clk) resetn = 1'b1; out_ready = 1'b1;
    #1;
    check("s6_rel_ready", in_ready, 1);
    tick();
    check("s6_dropped", out_valid, 0);
    in_valid = 1'b1; in_data = v2;
    tick();
    in_valid = 1'b0;
    check("s6_lat1", out_valid, 0);
    tick();
    check("s6_valid", out_valid, 1);
    check("s6_data", out_data, r2);
    check("s6_status", out_status, 8'hB0);
    tick();
    check("s6_single", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
